mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
- Parametrised memory-access pipeline stage; the next generation of the single-cycle MEM stage.
- Sits between EX and WB. Holds an internal byte-addressable data memory with sub-word loads and stores.
- Supports a configurable multi-cycle memory latency with a valid/ready handshake and stall.
- Resolves branches (pc_src), registers the MEM/WB fields, and carries destination-register metadata for forwarding.

Parameters:
- XLEN, 64, datapath width in bits; 32 or 64.
- DMEM_DEPTH, 256, number of XLEN-wide memory words; power of two.
- MEM_LATENCY, 2, cycles from acceptance of a load/store to its completion; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  stage can accept an operation this cycle.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double (3 is valid only when XLEN=64).
- mem_unsigned  in  1  zero-extend loads (1) or sign-extend loads (0).
- branch, zero  in  1 each  branch decision inputs.
- alu_result  in  XLEN  byte address for memory ops, or pass-through result.
- write_data  in  XLEN  store data, taken from the low bits.
- pc_branch_in  in  XLEN  branch target.
- mem_to_reg, reg_write  in  1 each  WB control.
- rd_in  in  5  destination register.
- out_valid  out  1  MEM/WB register holds a completed operation (one-cycle pulse per operation).
- out_result, out_read_data  out  XLEN  registered ALU result and extended load data.
- out_mem_to_reg, out_reg_write  out  1 each  registered WB control.
- out_rd  out  5  registered destination register.
- pc_src  out  1  branch taken; valid together with out_valid.
- pc_target  out  XLEN  registered branch target.

Behaviour:
- Reset (async assert, sync-deassert safe):
  - All out_* signals, pc_src, pc_target and the state go to 0/IDLE; in_ready = 1.
  - Memory contents are not reset.
  - If reset asserts mid-operation, the operation is aborted and a pending store is never committed.
- Handshake:
  - An operation is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (state == IDLE).
  - Inputs are captured into an internal holding register at acceptance, so EX may change them afterwards.
- FSM, IDLE/BUSY:
  - IDLE, accept a non-memory op (mem_read = mem_write = 0): stay IDLE. Next cycle out_valid = 1 (latency 1), so back-to-back throughput is 1 op per cycle.
  - IDLE, accept a memory op with MEM_LATENCY = 1: behaves as the non-memory case, plus the access.
  - IDLE, accept a memory op with MEM_LATENCY > 1: go to BUSY and load the counter with MEM_LATENCY-1.
  - BUSY: decrement the counter each cycle. At the edge where the counter reaches 0, perform the access, load MEM/WB, return to IDLE, and assert out_valid the following cycle.
  - Total load/store latency is MEM_LATENCY cycles, and in_ready is low for MEM_LATENCY-1 cycles.
- out_valid is a one-cycle pulse. All other outputs hold their last values.
- mem_read and mem_write asserted together: treated as a store; the load data returned is 0.
- Addressing:
  - Word index = alu_result[log2(XLEN/8) +: log2(DMEM_DEPTH)]; upper bits are ignored, so addresses wrap modulo the memory size.
  - Byte offset = alu_result[log2(XLEN/8)-1:0].
- Stores update only the addressed bytes (per-byte enables). The store commits at the completion edge.
- Loads:
  - Read at the completion edge, so a load issued after a store to the same address sees the new data.
  - The selected bytes are sign- or zero-extended to XLEN.
- Misaligned access (offset not a multiple of the access size): the offset is forced down to alignment by clearing its low bits.
- Branch: pc_src = captured branch & zero, registered with out_valid. pc_src is 0 whenever out_valid is 0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output out_misalign (1 bit, reset 0), registered with out_valid.
  - A misaligned access sets out_misalign = 1. A misaligned store does not modify memory, and a misaligned load returns out_read_data = 0.
  - Latency is unchanged.
- Undefined: the port is absent and the alignment-forcing behaviour above applies.

Test Plan:
- Parameters XLEN=64, DMEM_DEPTH=256, MEM_LATENCY=2 unless stated.
- Store double 0x1122334455667788 at 0x40, then load double at 0x40 -> out_read_data = 0x1122334455667788. in_ready is low for 1 cycle after each acceptance, and out_valid pulses 2 cycles after each acceptance.
- Store byte 0x80 at 0x43, then load byte signed at 0x43 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; load double at 0x40 -> 0x1122334480667788.
- Three back-to-back non-memory ops with alu_result = 1, 2, 3 and in_valid held high -> in_ready stays 1 and out_result = 1, 2, 3 on consecutive cycles.
- branch=1, zero=1, pc_branch_in=0x100 -> pc_src=1 and pc_target=0x100 with out_valid. With zero=0 -> pc_src=0.
- Wrap-around: store double 0xAA at 0x800, then load at 0x0 -> 0xAA. Reset asserted during BUSY of a store to 0x8 -> outputs cleared, in_ready=1, and a later load at 0x8 returns the prior contents.
- With MEM_MISALIGN_TRAP_EN: store half at 0x41 -> out_misalign=1 and memory is unchanged. Without the macro: a load half at 0x41 returns bytes 0x40–0x41.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe -- MEM pipeline stage between EX and WB.
//
// Purpose:
//   Owns a byte-addressable data memory (DMEM_DEPTH words of XLEN bits)
//   with byte/half/word/double loads and stores. Memory operations take
//   MEM_LATENCY cycles; non-memory operations complete in one cycle at full
//   throughput. Operands are captured into a holding register at acceptance,
//   so EX may change its outputs afterwards. This stage also resolves branches
//   (pc_src) and registers the MEM/WB fields.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   EX handshake; in_ready is high only while IDLE
//   mem_read/mem_write  load / store (both set: treated as a store)
//   mem_size            0=byte 1=half 2=word 3=double (double needs XLEN=64)
//   mem_unsigned        zero-extend (1) or sign-extend (0) load data
//   branch, zero        branch decision inputs
//   alu_result          byte address, or the pass-through result
//   write_data          store data, taken from the low bits
//   pc_branch_in        branch target
//   mem_to_reg, reg_write, rd_in   WB control and destination register
//   out_*               registered MEM/WB fields; out_valid is a 1-cycle pulse
//   pc_src, pc_target   branch taken (only while out_valid) and its target
//
// Optional build macro MEM_MISALIGN_TRAP_EN:
//   adds out_misalign. A misaligned access is flagged, a misaligned store
//   leaves memory untouched, and a misaligned load returns 0. Without the
//   macro the byte offset is forced down to the access alignment.
module mem_stage_pipe #(
  parameter int XLEN        = 64,
  parameter int DMEM_DEPTH  = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] write_data,
  input  logic [XLEN-1:0] pc_branch_in,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_read_data,
  output logic            out_mem_to_reg,
  output logic            out_reg_write,
  output logic [4:0]      out_rd,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            out_misalign
`endif
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DMEM_DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, complete;

  // Holding register for the accepted operation
  logic               h_read_q, h_write_q, h_uns_q, h_br_q, h_zero_q;
  logic               h_m2r_q, h_rw_q;
  logic [1:0]         h_size_q;
  logic [4:0]         h_rd_q;
  logic [XLEN-1:0]    h_alu_q, h_wdata_q, h_pc_q;

  // Operation being processed: live inputs while IDLE, held copy while BUSY
  logic               op_read, op_write, op_uns, op_br, op_zero, op_m2r, op_rw;
  logic [1:0]         op_size;
  logic [4:0]         op_rd;
  logic [XLEN-1:0]    op_alu, op_wdata, op_pc;

  logic [XLEN-1:0]    mem_q [DMEM_DEPTH];

  logic [1:0]         sz_eff;
  logic [OFF_W-1:0]   off, lo_mask, off_al;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W+2:0]   sh;
  logic [NB-1:0]      be;
  logic [XLEN-1:0]    wdata_sh, rdata_d;
  logic               we;

  // Byte-lane mask covering 2**sz bytes starting at lane 0
  function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  // Sign- or zero-extend the low 2**sz bytes of v to XLEN
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] sz,
                                             input logic uns);
    logic [XLEN-1:0] r;
    logic            s;
    case (sz)
      2'd0:    s = v[7];
      2'd1:    s = v[15];
      2'd2:    s = v[31];
      default: s = v[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) r[i] = (i < (8 << sz)) ? v[i] : (s & ~uns);
    return r;
  endfunction

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  assign op_read  = (state_q == IDLE) ? mem_read     : h_read_q;
  assign op_write = (state_q == IDLE) ? mem_write    : h_write_q;
  assign op_size  = (state_q == IDLE) ? mem_size     : h_size_q;
  assign op_uns   = (state_q == IDLE) ? mem_unsigned : h_uns_q;
  assign op_br    = (state_q == IDLE) ? branch       : h_br_q;
  assign op_zero  = (state_q == IDLE) ? zero         : h_zero_q;
  assign op_alu   = (state_q == IDLE) ? alu_result   : h_alu_q;
  assign op_wdata = (state_q == IDLE) ? write_data   : h_wdata_q;
  assign op_pc    = (state_q == IDLE) ? pc_branch_in : h_pc_q;
  assign op_m2r   = (state_q == IDLE) ? mem_to_reg   : h_m2r_q;
  assign op_rw    = (state_q == IDLE) ? reg_write    : h_rw_q;
  assign op_rd    = (state_q == IDLE) ? rd_in        : h_rd_q;

  // FSM next state; completion happens either at acceptance or on the BUSY
  // edge where the counter steps from 1 to 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((op_read || op_write) && (MEM_LATENCY > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      h_read_q  <= mem_read;
      h_write_q <= mem_write;
      h_size_q  <= mem_size;
      h_uns_q   <= mem_unsigned;
      h_br_q    <= branch;
      h_zero_q  <= zero;
      h_alu_q   <= alu_result;
      h_wdata_q <= write_data;
      h_pc_q    <= pc_branch_in;
      h_m2r_q   <= mem_to_reg;
      h_rw_q    <= reg_write;
      h_rd_q    <= rd_in;
    end
  end

  // Address decode; double accesses on a 32-bit datapath act as word accesses
  always_comb begin
    sz_eff = (XLEN == 32 && op_size == 2'd3) ? 2'd2 : op_size;
    case (sz_eff)
      2'd0:    lo_mask = '0;
      2'd1:    lo_mask = OFF_W'(1);
      2'd2:    lo_mask = OFF_W'(3);
      default: lo_mask = OFF_W'(7);
    endcase
    off      = op_alu[OFF_W-1:0];
    idx      = op_alu[OFF_W +: IDX_W];
    off_al   = off & ~lo_mask;
    sh       = {off_al, 3'b000};
    be       = size_mask(sz_eff) << off_al;
    wdata_sh = op_wdata << sh;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis = |(off & lo_mask);
  assign we  = complete && op_write && rst_n && !mis;
  assign rdata_d = (op_read && !op_write && !mis) ?
                   extend(mem_q[idx] >> sh, sz_eff, op_uns) : '0;
`else
  assign we  = complete && op_write && rst_n;
  assign rdata_d = (op_read && !op_write) ?
                   extend(mem_q[idx] >> sh, sz_eff, op_uns) : '0;
`endif

  // Byte-enabled store; memory contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      pc_src         <= 1'b0;
      out_result     <= '0;
      out_read_data  <= '0;
      out_mem_to_reg <= 1'b0;
      out_reg_write  <= 1'b0;
      out_rd         <= '0;
      pc_target      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misalign   <= 1'b0;
`endif
    end else begin
      out_valid <= complete;
      pc_src    <= complete && op_br && op_zero;
      if (complete) begin
        out_result     <= op_alu;
        out_read_data  <= rdata_d;
        out_mem_to_reg <= op_m2r;
        out_reg_write  <= op_rw;
        out_rd         <= op_rd;
        pc_target      <= op_pc;
`ifdef MEM_MISALIGN_TRAP_EN
        out_misalign   <= mis;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        branch, zero, mem_to_reg, reg_write;
  logic [63:0] alu_result, write_data, pc_branch_in;
  logic [4:0]  rd_in, out_rd;
  logic        out_valid, out_mem_to_reg, out_reg_write, pc_src;
  logic [63:0] out_result, out_read_data, pc_target;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_pipe #(.XLEN(64), .DMEM_DEPTH(256), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .branch(branch), .zero(zero),
    .alu_result(alu_result), .write_data(write_data),
    .pc_branch_in(pc_branch_in), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .rd_in(rd_in), .out_valid(out_valid),
    .out_result(out_result), .out_read_data(out_read_data),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .pc_src(pc_src), .pc_target(pc_target)
`ifdef MEM_MISALIGN_TRAP_EN
    , .out_misalign(out_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Issue one memory op, scramble EX outputs after acceptance, and check the
  // two-cycle handshake, the captured result and optionally the load data.
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic chk_data, input logic [63:0] exp_data);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; alu_result = addr; write_data = wdata;
    tick;
    idle_inputs;
    alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    chk({tag, ".busy_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, ".busy_valid"}, {63'd0, out_valid}, 64'd0);
    tick;
    chk({tag, ".done_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".done_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, ".result"}, out_result, addr);
    if (chk_data) chk({tag, ".rdata"}, out_read_data, exp_data);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs;
    mem_size = 2'd0; mem_unsigned = 1'b0; branch = 1'b0; zero = 1'b0;
    alu_result = '0; write_data = '0; pc_branch_in = '0;
    mem_to_reg = 1'b0; reg_write = 1'b0; rd_in = '0;
    tick;
    tick;
    chk("rst.valid", {63'd0, out_valid}, 64'd0);
    chk("rst.ready", {63'd0, in_ready}, 64'd1);
    chk("rst.result", out_result, 64'd0);
    chk("rst.pc_src", {63'd0, pc_src}, 64'd0);
    chk("rst.pc_target", pc_target, 64'd0);
    rst_n = 1'b1;
    tick;

    // Double store/load and byte merge with sign/zero extension
    mem_op("st_d40", 1'b0, 1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, 1'b0, 64'd0);
    mem_op("ld_d40", 1'b1, 1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 1'b1, 64'h1122334455667788);
    tick;
    chk("pulse_end", {63'd0, out_valid}, 64'd0);
    mem_op("st_b43", 1'b0, 1'b1, 2'd0, 1'b0, 64'h43, 64'h80, 1'b0, 64'd0);
    mem_op("ld_b43s", 1'b1, 1'b0, 2'd0, 1'b0, 64'h43, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
    mem_op("ld_b43u", 1'b1, 1'b0, 2'd0, 1'b1, 64'h43, 64'd0, 1'b1, 64'h80);
    mem_op("ld_d40b", 1'b1, 1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 1'b1, 64'h1122334480667788);
    mem_op("ld_w40s", 1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'd0, 1'b1, 64'hFFFFFFFF80667788);
    mem_op("ld_w44", 1'b1, 1'b0, 2'd2, 1'b0, 64'h44, 64'd0, 1'b1, 64'h11223344);
`ifndef MEM_MISALIGN_TRAP_EN
    mem_op("ld_h41", 1'b1, 1'b0, 2'd1, 1'b0, 64'h41, 64'd0, 1'b1, 64'h7788);
`else
    mem_op("st_h41", 1'b0, 1'b1, 2'd1, 1'b0, 64'h41, 64'hCDEF, 1'b0, 64'd0);
    chk("st_h41.mis", {63'd0, out_misalign}, 64'd1);
    mem_op("ld_d40c", 1'b1, 1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 1'b1, 64'h1122334480667788);
    chk("ld_d40c.mis", {63'd0, out_misalign}, 64'd0);
`endif

    // Read and write together acts as a store returning zero
    mem_op("rw_d10", 1'b1, 1'b1, 2'd3, 1'b0, 64'h10, 64'h77, 1'b1, 64'd0);
    mem_op("ld_d10", 1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b1, 64'h77);

    // Back-to-back non-memory ops at full throughput
    in_valid = 1'b1; rd_in = 5'd7; reg_write = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_result = 64'(i);
      tick;
      chk($sformatf("b2b%0d.valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("b2b%0d.ready", i), {63'd0, in_ready}, 64'd1);
      chk($sformatf("b2b%0d.result", i), out_result, 64'(i));
    end
    chk("b2b.rd", {59'd0, out_rd}, 64'd7);
    chk("b2b.reg_write", {63'd0, out_reg_write}, 64'd1);
    in_valid = 1'b0; reg_write = 1'b0; rd_in = '0;
    tick;
    chk("b2b.idle_valid", {63'd0, out_valid}, 64'd0);

    // Branch resolution
    in_valid = 1'b1; branch = 1'b1; zero = 1'b1; pc_branch_in = 64'h100;
    tick;
    chk("br_t.pc_src", {63'd0, pc_src}, 64'd1);
    chk("br_t.target", pc_target, 64'h100);
    zero = 1'b0; pc_branch_in = 64'h200;
    tick;
    chk("br_n.pc_src", {63'd0, pc_src}, 64'd0);
    chk("br_n.valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0; branch = 1'b0;
    tick;
    chk("br_idle.pc_src", {63'd0, pc_src}, 64'd0);
    chk("br_idle.target", pc_target, 64'h200);

    // Address wrap-around
    mem_op("st_d800", 1'b0, 1'b1, 2'd3, 1'b0, 64'h800, 64'hAA, 1'b0, 64'd0);
    mem_op("ld_d0", 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'd0, 1'b1, 64'hAA);

    // Reset during BUSY of a store aborts it
    mem_op("st_d8", 1'b0, 1'b1, 2'd3, 1'b0, 64'h8, 64'h1234, 1'b0, 64'd0);
    in_valid = 1'b1; mem_write = 1'b1; mem_size = 2'd3;
    alu_result = 64'h8; write_data = 64'hDEAD;
    tick;
    idle_inputs;
    chk("abort.busy_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort.ready", {63'd0, in_ready}, 64'd1);
    chk("abort.valid", {63'd0, out_valid}, 64'd0);
    chk("abort.result", out_result, 64'd0);
    chk("abort.target", pc_target, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    mem_op("ld_d8", 1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 1'b1, 64'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
